// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared kind codes, MIPS opcode/funct values and loader state enum.
// Optional feature macro: LOAD_USE_NOP_EN adds the STALL state used for load-use NOP insertion.
package instr_enc_pkg;
    localparam logic [2:0] K_ADD = 3'd0;
    localparam logic [2:0] K_SUB = 3'd1;
    localparam logic [2:0] K_LW  = 3'd2;
    localparam logic [2:0] K_SW  = 3'd3;
    localparam logic [2:0] K_BEQ = 3'd4;
    localparam logic [2:0] K_NOP = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

`ifdef LOAD_USE_NOP_EN
    typedef enum logic [1:0] {S_LOAD, S_STALL, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_LOAD, S_DONE} state_e;
`endif
endpackage

// File: rtl/instr_word_encode.sv
// instr_word_encode: combinational request -> 32-bit MIPS word, plus legality and register-read flags.
// Ports: kind/rs/rt/rd/imm in; word, legal, reads_rs, reads_rt out.
module instr_word_encode
    import instr_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal,
    output logic        reads_rs,
    output logic        reads_rt
);
    always_comb begin
        word     = '0;
        legal    = 1'b1;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        case (kind)
            K_ADD: begin
                word     = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            K_SUB: begin
                word     = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            K_LW: begin
                word     = {OP_LW, rs, rt, imm};
                reads_rs = 1'b1;
            end
            K_SW: begin
                word     = {OP_SW, rs, rt, imm};
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            K_BEQ: begin
                word     = {OP_BEQ, rs, rt, imm};
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            K_NOP: word = '0;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: loads encoded MIPS words sequentially into instruction memory.
// Ports: clk/reset; in_* request handshake; restart; imem_we/addr/wdata write port;
// word_count, done, err_illegal, err_overflow status (all registered except in_ready).
// Optional feature macro: LOAD_USE_NOP_EN inserts a NOP after an LW whose rt is read next.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       enc_word;
    logic              enc_legal, reads_rs, reads_rt;
    logic              accept, wr, wr_last;
    logic [31:0]       wr_data;

`ifdef LOAD_USE_NOP_EN
    logic [4:0]  prev_rt_q, prev_rt_d;
    logic [31:0] held_q, held_d;
    logic        held_last_q, held_last_d;
    logic        hazard;
    // prev_rt_q is the rt of the last written word if it was an LW, else 0 (r0 never hazards).
    assign hazard = prev_rt_q != 5'd0 &&
                    ((reads_rs && in_rs == prev_rt_q) || (reads_rt && in_rt == prev_rt_q));
`else
    logic unused_reads;
    assign unused_reads = reads_rs ^ reads_rt;
`endif

    instr_word_encode u_enc (
        .kind     (in_kind),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .word     (enc_word),
        .legal    (enc_legal),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt)
    );

    assign in_ready = !reset && state_q == S_LOAD && cnt_q < FULL;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        wr      = 1'b0;
        wr_data = enc_word;
        wr_last = in_last;
`ifdef LOAD_USE_NOP_EN
        prev_rt_d   = prev_rt_q;
        held_d      = held_q;
        held_last_d = held_last_q;
`endif
        if (state_q == S_DONE) begin
            ovf_d = ovf_q || in_valid;
            if (restart) begin
                state_d = S_LOAD;
                cnt_d   = '0;
                done_d  = 1'b0;
                ill_d   = 1'b0;
                ovf_d   = 1'b0;
`ifdef LOAD_USE_NOP_EN
                prev_rt_d = '0;
`endif
            end
        end
`ifdef LOAD_USE_NOP_EN
        else if (state_q == S_STALL) begin
            wr      = 1'b1;
            wr_data = held_q;
            wr_last = held_last_q;
            state_d = S_LOAD;
        end
`endif
        else if (accept) begin
            if (!enc_legal) begin
                ill_d = 1'b1;
                if (in_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
`ifdef LOAD_USE_NOP_EN
            else if (hazard && cnt_q == FULL - ONE) begin
                // No room for both the NOP and the request: drop it and close the image.
                ovf_d   = 1'b1;
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            else if (hazard) begin
                wr          = 1'b1;
                wr_data     = '0;
                wr_last     = 1'b0;
                held_d      = enc_word;
                held_last_d = in_last;
                state_d     = S_STALL;
                prev_rt_d   = in_kind == K_LW ? in_rt : 5'd0;
            end
`endif
            else begin
                wr = 1'b1;
`ifdef LOAD_USE_NOP_EN
                prev_rt_d = in_kind == K_LW ? in_rt : 5'd0;
`endif
            end
        end
        if (wr) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = wr_data;
            cnt_d   = cnt_q + ONE;
            if (wr_last || cnt_q + ONE == FULL) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef LOAD_USE_NOP_EN
            prev_rt_q   <= '0;
            held_q      <= '0;
            held_last_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
`ifdef LOAD_USE_NOP_EN
            prev_rt_q   <= prev_rt_d;
            held_q      <= held_d;
            held_last_q <= held_last_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign word_count   = cnt_q;
    assign done         = done_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;
endmodule
